// File: rtl/hwpe_ctrl_ctx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_ctx_sched_pkg
// Brief    : Shared types and constants for the multi-context job scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package hwpe_ctrl_ctx_sched_pkg;

    // Default number of job contexts held by the control slave register file.
    localparam int REGFILE_N_CONTEXT = 2;

    // Storage width of the owner field; covers up to 256 offloading cores.
    localparam int CTX_OWNER_W = 8;

    // Lifecycle of one job context.
    typedef enum logic [1:0] {
        CTX_FREE     = 2'd0,
        CTX_ACQUIRED = 2'd1,
        CTX_QUEUED   = 2'd2,
        CTX_RUNNING  = 2'd3
    } ctx_state_e;

    // One entry of the context ring.
    typedef struct packed {
        ctx_state_e             state;
        logic [CTX_OWNER_W-1:0] owner;
    } ctx_entry_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_ctrl_ctx_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_ctx_sched_if
// Brief    : Register-decode / engine side signals of the context scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface hwpe_ctrl_ctx_sched_if #(
    parameter int N_CONTEXT = hwpe_ctrl_ctx_sched_pkg::REGFILE_N_CONTEXT,
    parameter int N_CORES   = 16,
    parameter int FIN_CNT_W = 8
);
    localparam int CTX_W  = $clog2(N_CONTEXT);
    localparam int CORE_W = $clog2(N_CORES);

    logic                 clear_i;
    logic                 acq_req_i;
    logic [CORE_W-1:0]    acq_src_i;
    logic                 acq_ok_o;
    logic [CTX_W-1:0]     acq_ctx_o;
    logic                 commit_i;
    logic [CORE_W-1:0]    commit_src_i;
    logic                 commit_err_o;
    logic                 start_o;
    logic [CTX_W-1:0]     start_ctx_o;
    logic                 busy_o;
    logic                 done_i;
    logic [N_CORES-1:0]   evt_o;
    logic [FIN_CNT_W-1:0] finished_cnt_o;
    logic                 finished_clr_i;
    logic [N_CONTEXT-1:0] status_o;
    logic [CTX_W:0]       nb_queued_o;

    // Scheduler side.
    modport slave (
        input  clear_i, acq_req_i, acq_src_i, commit_i, commit_src_i,
               done_i, finished_clr_i,
        output acq_ok_o, acq_ctx_o, commit_err_o, start_o, start_ctx_o,
               busy_o, evt_o, finished_cnt_o, status_o, nb_queued_o
    );

    // Register decode / engine side.
    modport master (
        output clear_i, acq_req_i, acq_src_i, commit_i, commit_src_i,
               done_i, finished_clr_i,
        input  acq_ok_o, acq_ctx_o, commit_err_o, start_o, start_ctx_o,
               busy_o, evt_o, finished_cnt_o, status_o, nb_queued_o
    );

endinterface
`default_nettype wire

// File: rtl/hwpe_ctrl_ctx_sched_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_ctx_sched_sat_cnt
// Brief    : Saturating up-counter with read-clear; a clear coinciding with
//            an increment restarts the count at one.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_ctx_sched_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic      [WIDTH-1:0] o_cnt
);
    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;

    // Count increments, holding at the maximum; clear drops pending history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? WIDTH'(1) : '0;
        end else if (i_inc && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hwpe_ctrl_ctx_sched.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_ctrl_ctx_sched
// Brief    : N-context in-order job scheduler for the HWPE control slave.
//            Contexts form a ring: ptr allocates, head executes.
// Revision : 1.0 - initial release
// ============================================================================
module hwpe_ctrl_ctx_sched
    import hwpe_ctrl_ctx_sched_pkg::*;
#(
    parameter int N_CONTEXT = REGFILE_N_CONTEXT,
    parameter int N_CORES   = 16,
    parameter int FIN_CNT_W = 8
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    hwpe_ctrl_ctx_sched_if.slave   ctrl
);
    localparam int CTX_W  = $clog2(N_CONTEXT);
    localparam int CORE_W = $clog2(N_CORES);

    ctx_entry_t           r_ctx [N_CONTEXT];
    logic [CTX_W-1:0]     r_ptr;
    logic [CTX_W-1:0]     r_head;
    logic                 r_busy;
    logic                 r_start;
    logic                 r_commit_err;
    logic [N_CORES-1:0]   r_evt;

    logic                 w_rst;
    logic                 w_lock;
    ctx_entry_t           w_ptr_ent;
    ctx_entry_t           w_head_ent;
    logic                 w_acq_ok;
    logic                 w_commit_ok;
    logic                 w_dispatch;
    logic                 w_done;
    logic [N_CONTEXT-1:0] w_status;
    logic [CTX_W:0]       w_nb_queued;
    logic [FIN_CNT_W-1:0] w_fin_cnt;

    // Soft clear behaves exactly like the hardware reset.
    assign w_rst      = rst_i | ctrl.clear_i;
    assign w_ptr_ent  = r_ctx[r_ptr];
    assign w_head_ent = r_ctx[r_head];

    // Lock is held while any context sits in ACQUIRED.
    always_comb begin
        w_lock = 1'b0;
        for (int i = 0; i < N_CONTEXT; i++) begin
            if (r_ctx[i].state == CTX_ACQUIRED) begin
                w_lock = 1'b1;
            end
        end
    end

    // All decisions use the registered state only, so same-cycle events
    // never see each other's effect.
    assign w_acq_ok    = ctrl.acq_req_i && !w_lock && (w_ptr_ent.state == CTX_FREE);
    assign w_commit_ok = ctrl.commit_i && (w_ptr_ent.state == CTX_ACQUIRED) &&
                         (w_ptr_ent.owner == CTX_OWNER_W'(ctrl.commit_src_i));
    assign w_dispatch  = !r_busy && (w_head_ent.state == CTX_QUEUED);
    assign w_done      = ctrl.done_i && r_busy;

    // Context ring, pointers and registered pulses.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                r_ctx[i].state <= CTX_FREE;
                r_ctx[i].owner <= '0;
            end
            r_ptr        <= '0;
            r_head       <= '0;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_commit_err <= 1'b0;
            r_evt        <= '0;
        end else begin
            // Acquire and commit both target ctx[ptr] but are mutually
            // exclusive (FREE vs ACQUIRED); dispatch and done both target
            // ctx[head] but are exclusive on r_busy.
            if (w_acq_ok) begin
                r_ctx[r_ptr].state <= CTX_ACQUIRED;
                r_ctx[r_ptr].owner <= CTX_OWNER_W'(ctrl.acq_src_i);
            end
            if (w_commit_ok) begin
                r_ctx[r_ptr].state <= CTX_QUEUED;
                r_ptr              <= r_ptr + CTX_W'(1);
            end
            if (w_dispatch) begin
                r_ctx[r_head].state <= CTX_RUNNING;
            end
            if (w_done) begin
                r_ctx[r_head].state <= CTX_FREE;
                r_head              <= r_head + CTX_W'(1);
            end

            if (w_dispatch) begin
                r_busy <= 1'b1;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end

            r_start      <= w_dispatch;
            r_commit_err <= ctrl.commit_i && !w_commit_ok;
            for (int i = 0; i < N_CORES; i++) begin
                r_evt[i] <= w_done && (w_head_ent.owner == CTX_OWNER_W'(i));
            end
        end
    end

    // Occupancy summary derived purely from the registered ring.
    always_comb begin
        w_status    = '0;
        w_nb_queued = '0;
        for (int i = 0; i < N_CONTEXT; i++) begin
            w_status[i] = (r_ctx[i].state != CTX_FREE);
            if (r_ctx[i].state == CTX_QUEUED) begin
                w_nb_queued = w_nb_queued + (CTX_W+1)'(1);
            end
        end
    end

    hwpe_ctrl_ctx_sched_sat_cnt #(
        .WIDTH (FIN_CNT_W)
    ) u_fin_cnt (
        .clk   (clk_i),
        .rst   (w_rst),
        .i_clr (ctrl.finished_clr_i),
        .i_inc (w_done),
        .o_cnt (w_fin_cnt)
    );

    assign ctrl.acq_ok_o       = w_acq_ok;
    assign ctrl.acq_ctx_o      = r_ptr;
    assign ctrl.commit_err_o   = r_commit_err;
    assign ctrl.start_o        = r_start;
    assign ctrl.start_ctx_o    = r_head;
    assign ctrl.busy_o         = r_busy;
    assign ctrl.evt_o          = r_evt;
    assign ctrl.finished_cnt_o = w_fin_cnt;
    assign ctrl.status_o       = w_status;
    assign ctrl.nb_queued_o    = w_nb_queued;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_ctrl_ctx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwpe_ctrl_ctx_sched
// Brief    : Directed self-checking bench for hwpe_ctrl_ctx_sched
//            (2 contexts, 4 cores, 8-bit finished counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_ctrl_ctx_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    hwpe_ctrl_ctx_sched_if #(.N_CONTEXT(2), .N_CORES(4), .FIN_CNT_W(8)) sif ();

    hwpe_ctrl_ctx_sched #(
        .N_CONTEXT (2),
        .N_CORES   (4),
        .FIN_CNT_W (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctrl  (sif.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one edge and settle; registered outputs then reflect the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete job on an idle engine; optional read-clear during done.
    task automatic run_job(input int src, input logic clr);
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'(src);
        tick();
        sif.acq_req_i = 1'b0;
        sif.commit_i = 1'b1; sif.commit_src_i = 2'(src);
        tick();
        sif.commit_i = 1'b0;
        tick();
        sif.done_i = 1'b1; sif.finished_clr_i = clr;
        tick();
        sif.done_i = 1'b0; sif.finished_clr_i = 1'b0;
    endtask

    // Linear directed sequence.
    initial begin
        sif.clear_i = 1'b0; sif.acq_req_i = 1'b0; sif.acq_src_i = '0;
        sif.commit_i = 1'b0; sif.commit_src_i = '0; sif.done_i = 1'b0;
        sif.finished_clr_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 32'(sif.busy_o), 0);
        check("rst_status", 32'(sif.status_o), 0);
        check("rst_nbq", 32'(sif.nb_queued_o), 0);
        check("rst_fin", 32'(sif.finished_cnt_o), 0);
        check("rst_evt", 32'(sif.evt_o), 0);
        check("rst_start", 32'(sif.start_o), 0);

        // ---- basic job, core 2 ----
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd2; #1;
        check("basic_acq_ok", 32'(sif.acq_ok_o), 1);
        check("basic_acq_ctx", 32'(sif.acq_ctx_o), 0);
        tick();
        sif.acq_req_i = 1'b0;
        check("basic_status_acq", 32'(sif.status_o), 1);
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd2;
        tick();
        sif.commit_i = 1'b0;
        check("basic_start_early", 32'(sif.start_o), 0);
        check("basic_nbq", 32'(sif.nb_queued_o), 1);
        tick();
        check("basic_start", 32'(sif.start_o), 1);
        check("basic_start_ctx", 32'(sif.start_ctx_o), 0);
        check("basic_busy", 32'(sif.busy_o), 1);
        tick();
        check("basic_start_pulse", 32'(sif.start_o), 0);
        sif.done_i = 1'b1;
        tick();
        sif.done_i = 1'b0;
        check("basic_evt", 32'(sif.evt_o), 32'b0100);
        check("basic_fin", 32'(sif.finished_cnt_o), 1);
        check("basic_status_done", 32'(sif.status_o), 0);
        check("basic_busy_done", 32'(sif.busy_o), 0);
        tick();
        check("basic_evt_pulse", 32'(sif.evt_o), 0);

        // ---- lock and ownership, core 1 on ctx 1 ----
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd1; #1;
        check("lock_acq_ok", 32'(sif.acq_ok_o), 1);
        check("lock_acq_ctx", 32'(sif.acq_ctx_o), 1);
        tick();
        sif.acq_src_i = 2'd0; #1;
        check("lock_second_acq", 32'(sif.acq_ok_o), 0);
        sif.acq_req_i = 1'b0;
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd3;
        tick();
        sif.commit_i = 1'b0;
        check("own_commit_err", 32'(sif.commit_err_o), 1);
        check("own_status", 32'(sif.status_o), 32'b10);
        check("own_nbq", 32'(sif.nb_queued_o), 0);
        tick();
        check("own_err_pulse", 32'(sif.commit_err_o), 0);
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd1;
        tick();
        sif.commit_i = 1'b0;
        check("own_commit_ok", 32'(sif.commit_err_o), 0);
        check("own_nbq_ok", 32'(sif.nb_queued_o), 1);
        tick();
        check("own_start", 32'(sif.start_o), 1);
        check("own_start_ctx", 32'(sif.start_ctx_o), 1);
        sif.done_i = 1'b1;
        tick();
        sif.done_i = 1'b0;
        check("own_evt", 32'(sif.evt_o), 32'b0010);
        check("own_fin", 32'(sif.finished_cnt_o), 2);

        // ---- full and wrap ----
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd0;
        tick();
        sif.acq_req_i = 1'b0;
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd0;
        tick();
        sif.commit_i = 1'b0;
        tick();
        check("full_start0", 32'(sif.start_o), 1);
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd3; #1;
        check("full_acq1_ctx", 32'(sif.acq_ctx_o), 1);
        tick();
        sif.acq_req_i = 1'b0;
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd3;
        tick();
        sif.commit_i = 1'b0;
        check("full_status", 32'(sif.status_o), 32'b11);
        check("full_nbq", 32'(sif.nb_queued_o), 1);
        check("full_busy", 32'(sif.busy_o), 1);
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd2; #1;
        check("full_acq_fail", 32'(sif.acq_ok_o), 0);
        sif.acq_req_i = 1'b0;
        sif.done_i = 1'b1;
        tick();
        sif.done_i = 1'b0;
        check("full_evt0", 32'(sif.evt_o), 32'b0001);
        check("full_status_after", 32'(sif.status_o), 32'b10);
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd2; #1;
        check("wrap_acq_ok", 32'(sif.acq_ok_o), 1);
        check("wrap_acq_ctx", 32'(sif.acq_ctx_o), 0);
        tick();
        sif.acq_req_i = 1'b0;
        check("order_start1", 32'(sif.start_o), 1);
        check("order_ctx1", 32'(sif.start_ctx_o), 1);
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd2;
        tick();
        sif.commit_i = 1'b0;
        sif.done_i = 1'b1;
        tick();
        sif.done_i = 1'b0;
        check("order_evt3", 32'(sif.evt_o), 32'b1000);
        tick();
        check("order_start0", 32'(sif.start_o), 1);
        check("order_ctx0", 32'(sif.start_ctx_o), 0);
        sif.done_i = 1'b1;
        tick();
        sif.done_i = 1'b0;
        check("order_evt2", 32'(sif.evt_o), 32'b0100);
        check("order_fin", 32'(sif.finished_cnt_o), 5);

        // ---- saturation and clear ----
        for (int k = 0; k < 250; k++) run_job(k % 4, 1'b0);
        check("sat_255", 32'(sif.finished_cnt_o), 255);
        run_job(1, 1'b0);
        check("sat_hold", 32'(sif.finished_cnt_o), 255);
        run_job(2, 1'b1);
        check("clr_with_done", 32'(sif.finished_cnt_o), 1);

        // ---- spurious done while idle ----
        sif.done_i = 1'b1;
        tick();
        sif.done_i = 1'b0;
        check("spur_evt", 32'(sif.evt_o), 0);
        check("spur_fin", 32'(sif.finished_cnt_o), 1);
        check("spur_busy", 32'(sif.busy_o), 0);

        sif.finished_clr_i = 1'b1;
        tick();
        sif.finished_clr_i = 1'b0;
        check("clr_alone", 32'(sif.finished_cnt_o), 0);

        // ---- reset mid-operation ----
        run_job(3, 1'b0);
        check("mid_fin_pre", 32'(sif.finished_cnt_o), 1);
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd0;
        tick();
        sif.acq_req_i = 1'b0;
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd0;
        tick();
        sif.commit_i = 1'b0;
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd1;
        tick();
        sif.acq_req_i = 1'b0;
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd1;
        tick();
        sif.commit_i = 1'b0;
        check("mid_busy_pre", 32'(sif.busy_o), 1);
        check("mid_nbq_pre", 32'(sif.nb_queued_o), 1);
        rst = 1'b1; sif.done_i = 1'b1;
        tick();
        rst = 1'b0; sif.done_i = 1'b0;
        check("mid_busy", 32'(sif.busy_o), 0);
        check("mid_status", 32'(sif.status_o), 0);
        check("mid_nbq", 32'(sif.nb_queued_o), 0);
        check("mid_evt", 32'(sif.evt_o), 0);
        check("mid_fin", 32'(sif.finished_cnt_o), 0);
        tick();
        check("mid_evt_late", 32'(sif.evt_o), 0);
        check("mid_start_late", 32'(sif.start_o), 0);

        // ---- acquire racing a commit sees the lock ----
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd1;
        tick();
        sif.acq_src_i = 2'd2;
        sif.commit_i = 1'b1; sif.commit_src_i = 2'd1; #1;
        check("race_acq_fail", 32'(sif.acq_ok_o), 0);
        tick();
        sif.acq_req_i = 1'b0; sif.commit_i = 1'b0;
        check("race_status", 32'(sif.status_o), 32'b01);

        // ---- soft clear ----
        sif.clear_i = 1'b1;
        tick();
        sif.clear_i = 1'b0;
        check("clear_status", 32'(sif.status_o), 0);
        check("clear_start", 32'(sif.start_o), 0);
        sif.acq_req_i = 1'b1; sif.acq_src_i = 2'd3; #1;
        check("clear_acq_ctx", 32'(sif.acq_ctx_o), 0);
        check("clear_acq_ok", 32'(sif.acq_ok_o), 1);
        sif.acq_req_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hwpe_ctrl_ctx_sched.md
Name: hwpe_ctrl_ctx_sched

Overview:
Parametrised multi-context job scheduler for the HWPE control slave. It generalises the fixed two-context acquire/commit/running scheme to N_CONTEXT contexts held in a ring, dispatched strictly in order. Each context records its owner core. Per-core completion events and a saturating finished counter are generated. It sits between the control-slave register decode (ACQUIRE/TRIGGER/FINISHED/STATUS/SOFTCLEAR) and the engine start/done handshake.

Parameters:
N_CONTEXT, 2, number of job contexts; power of two, >=2; CTX_W = $clog2(N_CONTEXT)
N_CORES, 16, number of offloading cores; CORE_W = $clog2(N_CORES)
FIN_CNT_W, 8, width of the finished-jobs counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
clear_i  in  1  soft clear; identical effect to rst_i
acq_req_i  in  1  acquire attempt (ACQUIRE register read)
acq_src_i  in  CORE_W  requesting core id
acq_ok_o  out  1  combinational; acquire granted, valid while acq_req_i=1
acq_ctx_o  out  CTX_W  combinational; granted context id (= pointer context)
commit_i  in  1  commit/trigger of the acquired context
commit_src_i  in  CORE_W  committing core id
commit_err_o  out  1  registered pulse; commit rejected
start_o  out  1  registered pulse; engine start
start_ctx_o  out  CTX_W  running context id (head), stable while busy_o
busy_o  out  1  engine running
done_i  in  1  engine done pulse
evt_o  out  N_CORES  registered one-hot pulse to the owner of the completed job
finished_cnt_o  out  FIN_CNT_W  saturating count of completed jobs
finished_clr_i  in  1  clears finished counter (read-clear)
status_o  out  N_CONTEXT  bit i = context i not FREE
nb_queued_o  out  CTX_W+1  number of contexts in QUEUED state

Behaviour:
- Per-context state: FREE, ACQUIRED, QUEUED, RUNNING, plus a CORE_W owner field. Pointers: ptr (allocation), head (execution), both mod N_CONTEXT.
- Reset or clear_i: all contexts FREE; ptr=head=0; busy_o=0; all pulses 0; finished_cnt_o=0; status_o=0; nb_queued_o=0. Reset mid-job abandons the job. A done_i in the same cycle is ignored.
- Lock: at most one context may be ACQUIRED at any time.
- Acquire: acq_ok_o = acq_req_i & no context ACQUIRED & ctx[ptr]==FREE. acq_ctx_o = ptr. On grant, at t+1: ctx[ptr]=ACQUIRED, owner=acq_src_i. ptr does not advance.
- Full condition: all contexts non-FREE, so acq_ok_o=0. Lock held also gives acq_ok_o=0. A failed acquire has no side effects.
- Commit: accepted if ctx[ptr]==ACQUIRED and commit_src_i==owner. On accept, at t+1: ctx[ptr]=QUEUED and ptr=ptr+1 (wraps). Otherwise commit_err_o=1 at t+1 and there is no state change.
- Dispatch: when busy_o=0 and ctx[head]==QUEUED, at t+1: start_o=1 (one cycle), busy_o=1, ctx[head]=RUNNING. start_ctx_o=head.
- Minimum latency: commit at t leads to QUEUED at t+1 and start_o at t+2.
- Done: done_i while busy_o=1 gives, at t+1: ctx[head]=FREE, head+1, busy_o=0, evt_o[owner]=1, finished counter +1. done_i while busy_o=0 is ignored.
- Back-to-back jobs: done at t, next start_o at t+2.
- Finished counter saturates at 2^FIN_CNT_W-1. finished_clr_i together with done_i gives 1. finished_clr_i alone gives 0.
- Simultaneous events:
  - Acquire and commit in the same cycle: the acquire is evaluated on the pre-commit state (lock held), so it fails.
  - Commit and done in the same cycle: both apply.
  - Done freeing ctx[ptr] and an acquire in the same cycle: the acquire fails that cycle (uses current state).
- status_o and nb_queued_o are derived from registered state (no input feed-through).

Decomposition:
- hwpe_ctrl_package additions:
  - ctx_state_e enum {CTX_FREE, CTX_ACQUIRED, CTX_QUEUED, CTX_RUNNING}
  - REGFILE_N_CONTEXT reused as the default for N_CONTEXT
  - ctx_entry_t packed struct {state, owner}
- Optional sub-module hwpe_ctrl_sat_cnt (saturating counter with clear and increment) for finished_cnt_o. Everything else stays in one module.

Test Plan:
(N_CONTEXT=2, N_CORES=4, FIN_CNT_W=8)
- Basic job: acquire src=2 -> acq_ok_o=1, acq_ctx_o=0; commit src=2 -> start_o at +2 cycles, start_ctx_o=0; done_i -> evt_o=4'b0100, finished_cnt_o=1, status_o=0.
- Lock and ownership:
  - Acquire src=1 then a second acquire before commit -> second acq_ok_o=0.
  - Commit src=3 -> commit_err_o=1 and the context stays ACQUIRED.
  - Commit src=1 -> accepted.
- Full and wrap:
  - Two jobs committed while the engine is stalled -> status_o=2'b11, third acquire fails.
  - After done -> acquire succeeds with acq_ctx_o=0 (wrap).
  - Jobs run in order 0,1.
- Saturation and clear:
  - 256 dones -> finished_cnt_o=255.
  - done with finished_clr_i -> 1.
  - finished_clr_i alone -> 0.
- Reset mid-operation: rst_i while busy with one context QUEUED -> next cycle busy_o=0, status_o=0, nb_queued_o=0; a coincident done_i is ignored and no evt_o pulse.
- Spurious done_i with busy_o=0 -> no evt_o, counter unchanged.
